compress_unit: RTL and testbench
================================

// Module: compress_unit
// PURPOSE
//  Multi-lane, pipelined Kyber coefficient compressor/decompressor (q = 3329).
//  Mode 0: Compress_q(x,d) = round(2^d*x/q) mod 2^d. Mode 1: Decompress_q(y,d) = round(q*y/2^d).
//  Supports d in {1,4,5,10,11}. Sits between the NTT/poly datapath and the ciphertext packer/unpacker.
//  Valid/ready streaming with full backpressure.
// PARAMETERS
//  LANES   4    coefficients processed per beat
//  CW      12   coefficient width (must be >= 12)
//  TAG_W   8    sideband tag width, passed through unchanged alongside each beat
// PORTS
//  i_clk    in   1           clock, rising edge
//  i_rst    in   1           asynchronous reset, active high
//  i_valid  in   1           input beat valid
//  o_ready  out  1           unit can accept an input beat this cycle
//  i_mode   in   1           0 = compress, 1 = decompress
//  i_d      in   4           bit depth d
//  i_coeff  in   LANES*CW    input coefficients; lane k = i_coeff[k*CW +: CW]
//  i_tag    in   TAG_W       sideband tag
//  o_valid  out  1           output beat valid
//  i_ready  in   1           downstream accepts output beat
//  o_coeff  out  LANES*CW    results, zero-extended to CW
//  o_tag    out  TAG_W       tag of the beat
//  o_err    out  1           beat had unsupported d; o_coeff is all zero
//  o_busy   out  1           any pipeline stage holds a valid beat
// BEHAVIOUR
//  Reset: all stage valid bits clear; o_valid=0, o_coeff=0, o_tag=0, o_err=0, o_busy=0.
//   o_ready=1 once reset is released.
//  Pipeline: 3 stages (S1 reduce/select, S2 multiply, S3 round/shift/mask).
//   Latency is 3 cycles from input handshake to o_valid with no stall. Throughput is 1 beat/cycle.
//  Handshake: input transfer occurs when i_valid & o_ready; output transfer when o_valid & i_ready.
//   Stage n loads when it is empty or its contents move to stage n+1 in the same cycle.
//   S3 drains on i_ready. o_ready = ~S1_valid | S1_advances.
//   Bubbles collapse: a stalled S3 does not block S1/S2 from filling.
//  o_ready is combinational from i_ready and the stage valids; there is no path from i_valid to o_ready.
//  While o_valid=1 & i_ready=0, o_coeff/o_tag/o_err hold stable.
//  Compress arithmetic, per lane:
//   - x >= 3329 is reduced once by subtracting 3329 (4095 -> 766).
//   - r = floor((x*2^d + 1664)/3329) & (2^d-1). Ties cannot occur because q is odd.
//   - The result must be bit-exact for every x in [0,4095] and each supported d.
//   - Division is implemented by constant multiply and shift (no divider). Internal widths must lose no bits.
//  Decompress arithmetic, per lane:
//   - y is masked to its low d bits.
//   - r = (3329*y + 2^(d-1)) >> d. Result is always < 3329.
//  Unsupported d (anything other than 1,4,5,10,11), either mode: lane results are 0, and o_err=1 for that beat.
//  The beat still flows with normal latency and ordering.
//  i_mode, i_d and i_tag are captured per beat.
//  Beats with different mode/d may be issued back-to-back; each beat uses its own settings.
//  Reset asserted mid-operation: all in-flight beats are discarded immediately. No output beat is emitted for them.
// TESTING
//  1 compress d=1, lanes x={832,833,2496,2497} -> {0,1,1,0}.
//  2 compress d=10 x={1665,0,3328,4095} -> {512,0,0,236}; d=11 x=100 -> 62; d=4 x=3328 -> 0.
//  3 decompress d=1 y=1 -> 1665; d=4 y=15 -> 3121; d=11 y=2047 -> 3327; d=5 y=32 (masked) -> 0.
//  4 i_d=3, x=1000 in all lanes -> o_coeff=0, o_err=1, tag preserved; next beat with d=4 -> o_err=0.
//  5 stream 10 beats, tags 0..9, i_ready toggled 1,0,0,1 repeating ->
//    all 10 emerge in order, unchanged values, no drops or duplicates; o_ready=0 only when all 3 stages are full and stalled.
//  6 assert i_rst with 3 beats in flight -> o_valid=0 next edge, o_busy=0.
//    After release, a new beat x=833 d=1 appears exactly 3 cycles after handshake with value 1.
//  Exhaustive: all x in [0,4095] x each d, both modes, checked against a reference model (random i_ready).

Source files
------------

// File: rtl/compress_unit.sv
// Kyber (q = 3329) coefficient compressor/decompressor: LANES coefficients per beat,
// three-stage valid/ready pipeline (reduce/select, multiply, round/shift/mask).
module compress_unit #(
    parameter int LANES = 4,
    parameter int CW    = 12,
    parameter int TAG_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_mode,
    input  logic [3:0]            i_d,
    input  logic [LANES*CW-1:0]   i_coeff,
    input  logic [TAG_W-1:0]      i_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [LANES*CW-1:0]   o_coeff,
    output logic [TAG_W-1:0]      o_tag,
    output logic                  o_err,
    output logic                  o_busy
);

    localparam int          AW    = 23;     // holds x*2^11 + 1664 and any masked y
    localparam int          PW    = 47;     // AW x 24-bit constant, lossless
    localparam int          SH    = 35;
    localparam logic [11:0] Q     = 12'd3329;
    // ceil(2^35/3329); error term 2492*N stays below 2^35 for every N < 2^23, so floor is exact
    localparam logic [23:0] MAGIC = 24'd10321340;

    logic s1_valid, s2_valid, s3_valid;
    logic s1_free, s2_free, s3_free;

    assign s3_free = ~s3_valid | i_ready;
    assign s2_free = ~s2_valid | s3_free;
    assign s1_free = ~s1_valid | s2_free;
    assign o_ready = s1_free;
    assign o_valid = s3_valid;
    assign o_busy  = s1_valid | s2_valid | s3_valid;

    // S1: reduce x below q and form the multiplier operand
    logic [11:0]   in_mask;
    logic          in_d_ok;
    logic [11:0]   x_raw     [LANES];
    logic [11:0]   x_red     [LANES];
    logic [AW-1:0] s1_a_next [LANES];

    assign in_mask = (12'd1 << i_d) - 12'd1;
    assign in_d_ok = (i_d == 4'd1) || (i_d == 4'd4) || (i_d == 4'd5) ||
                     (i_d == 4'd10) || (i_d == 4'd11);

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            x_raw[k]     = i_coeff[k*CW +: 12];
            x_red[k]     = (x_raw[k] >= Q) ? x_raw[k] - Q : x_raw[k];
            s1_a_next[k] = i_mode ? AW'(x_raw[k] & in_mask)
                                  : (AW'(x_red[k]) << i_d) + AW'(1664);
        end
    end

    logic [AW-1:0]    s1_a [LANES];
    logic             s1_mode, s1_err;
    logic [3:0]       s1_d;
    logic [TAG_W-1:0] s1_tag;

    // S2: one multiply per lane; compress uses the reciprocal, decompress uses q plus half-LSB
    logic [PW-1:0] s2_p_next [LANES];
    logic [23:0]   s1_mult;
    logic [PW-1:0] s1_half;

    assign s1_mult = s1_mode ? 24'(Q) : MAGIC;
    assign s1_half = s1_mode ? PW'((12'd1 << s1_d) >> 1) : '0;

    always_comb begin
        for (int k = 0; k < LANES; k++)
            s2_p_next[k] = {24'b0, s1_a[k]} * {23'b0, s1_mult} + s1_half;
    end

    logic [PW-1:0]    s2_p [LANES];
    logic             s2_mode, s2_err;
    logic [3:0]       s2_d;
    logic [TAG_W-1:0] s2_tag;

    // S3: take the quotient (compress) or shift by d (decompress), mask, zero unsupported d
    logic [11:0]         s2_mask;
    logic [LANES*CW-1:0] s3_next;

    assign s2_mask = (12'd1 << s2_d) - 12'd1;

    always_comb begin
        s3_next = '0;
        for (int k = 0; k < LANES; k++) begin
            if (!s2_err)
                s3_next[k*CW +: CW] = s2_mode ? CW'(12'(s2_p[k] >> s2_d))
                                              : CW'(12'(s2_p[k] >> SH) & s2_mask);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            if (s1_free) s1_valid <= i_valid;
            if (s2_free) s2_valid <= s1_valid;
            if (s3_free) s3_valid <= s2_valid;
        end
    end

    // NOTE: datapath registers are reset as well so outputs read zero straight out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < LANES; k++) begin
                s1_a[k] <= '0;
                s2_p[k] <= '0;
            end
            s1_mode <= 1'b0;
            s1_err  <= 1'b0;
            s1_d    <= '0;
            s1_tag  <= '0;
            s2_mode <= 1'b0;
            s2_err  <= 1'b0;
            s2_d    <= '0;
            s2_tag  <= '0;
            o_coeff <= '0;
            o_tag   <= '0;
            o_err   <= 1'b0;
        end else begin
            if (s1_free && i_valid) begin
                for (int k = 0; k < LANES; k++) s1_a[k] <= s1_a_next[k];
                s1_mode <= i_mode;
                s1_err  <= ~in_d_ok;
                s1_d    <= i_d;
                s1_tag  <= i_tag;
            end
            if (s2_free && s1_valid) begin
                for (int k = 0; k < LANES; k++) s2_p[k] <= s2_p_next[k];
                s2_mode <= s1_mode;
                s2_err  <= s1_err;
                s2_d    <= s1_d;
                s2_tag  <= s1_tag;
            end
            if (s3_free && s2_valid) begin
                o_coeff <= s3_next;
                o_tag   <= s2_tag;
                o_err   <= s2_err;
            end
        end
    end

endmodule

// File: tb/tb_compress_unit.sv
// Directed and exhaustive bench for compress_unit: fixed vectors, streaming with
// backpressure, mid-flight reset and a full sweep against an integer reference model.
module tb_compress_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_mode;
    logic [3:0]  i_d;
    logic [47:0] i_coeff;
    logic [7:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [47:0] o_coeff;
    logic [7:0]  o_tag;
    logic        o_err;
    logic        o_busy;

    int checks   = 0;
    int failures = 0;

    compress_unit #(.LANES(4), .CW(12), .TAG_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_mode(i_mode), .i_d(i_d), .i_coeff(i_coeff), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_coeff(o_coeff), .o_tag(o_tag),
        .o_err(o_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [47:0] pack4(input int a, input int b, input int c, input int e);
        return {12'(e), 12'(c), 12'(b), 12'(a)};
    endfunction

    function automatic logic d_ok(input int d);
        return (d == 1) || (d == 4) || (d == 5) || (d == 10) || (d == 11);
    endfunction

    // Straight integer definition of the two functions, using true division.
    function automatic int ref_model(input logic mode, input int d, input int x);
        int xr, y;
        if (!d_ok(d)) return 0;
        if (!mode) begin
            xr = (x >= 3329) ? x - 3329 : x;
            return ((xr * (1 << d) + 1664) / 3329) % (1 << d);
        end
        y = x % (1 << d);
        return (3329 * y + (1 << (d - 1))) / (1 << d);
    endfunction

    function automatic logic [47:0] ref_beat(input logic mode, input int d, input logic [47:0] c);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            r[k*12 +: 12] = 12'(ref_model(mode, d, int'(c[k*12 +: 12])));
        return r;
    endfunction

    // One beat through an otherwise idle pipeline; lat counts rising edges from the handshake edge.
    task automatic send_one(input logic mode, input logic [3:0] d, input logic [47:0] coeff,
                            input logic [7:0] tag, output logic [47:0] rc, output logic [7:0] rt,
                            output logic re, output int lat);
        int w;
        @(negedge i_clk);
        i_ready = 1'b1;
        i_mode  = mode;
        i_d     = d;
        i_coeff = coeff;
        i_tag   = tag;
        i_valid = 1'b1;
        #1;
        w = 0;
        while (!o_ready && w < 20) begin
            @(negedge i_clk);
            #1;
            w++;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge i_clk);
            lat++;
        end
        rc = o_coeff;
        rt = o_tag;
        re = o_err;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_mode = 1'b0;
        i_d = 4'd0; i_coeff = '0; i_tag = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_coeff !== 48'h0) begin failures++; $display("FAIL reset_o_coeff got=%h exp=0", o_coeff); end
        checks++; if (o_tag !== 8'h0) begin failures++; $display("FAIL reset_o_tag got=%h exp=0", o_tag); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_o_err got=%b exp=0", o_err); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_o_busy got=%b exp=0", o_busy); end
        i_rst = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_compress_d1;
        logic [47:0] rc; logic [7:0] rt; logic re; int lat;
        send_one(1'b0, 4'd1, pack4(832, 833, 2496, 2497), 8'h11, rc, rt, re, lat);
        checks++; if (rc !== pack4(0, 1, 1, 0)) begin failures++; $display("FAIL compress_d1 got=%h exp=%h", rc, pack4(0, 1, 1, 0)); end
        checks++; if (re !== 1'b0) begin failures++; $display("FAIL compress_d1_err got=%b exp=0", re); end
        checks++; if (rt !== 8'h11) begin failures++; $display("FAIL compress_d1_tag got=%h exp=11", rt); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL compress_d1_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_compress_vectors;
        logic [3:0]  dv [3];
        logic [47:0] xv [3];
        logic [47:0] ev [3];
        logic [47:0] rc; logic [7:0] rt; logic re; int lat;
        dv[0] = 4'd10; xv[0] = pack4(1665, 0, 3328, 4095); ev[0] = pack4(512, 0, 0, 236);
        dv[1] = 4'd11; xv[1] = pack4(100, 100, 100, 100);  ev[1] = pack4(62, 62, 62, 62);
        dv[2] = 4'd4;  xv[2] = pack4(3328, 3328, 3328, 3328); ev[2] = pack4(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            send_one(1'b0, dv[i], xv[i], 8'(8'h20 + i), rc, rt, re, lat);
            checks++; if (rc !== ev[i]) begin failures++; $display("FAIL compress_vec%0d got=%h exp=%h", i, rc, ev[i]); end
            checks++; if (re !== 1'b0) begin failures++; $display("FAIL compress_vec%0d_err got=%b exp=0", i, re); end
        end
    endtask

    task automatic test_decompress_vectors;
        logic [3:0]  dv [4];
        logic [47:0] yv [4];
        logic [47:0] ev [4];
        logic [47:0] rc; logic [7:0] rt; logic re; int lat;
        dv[0] = 4'd1;  yv[0] = pack4(1, 1, 1, 1);         ev[0] = pack4(1665, 1665, 1665, 1665);
        dv[1] = 4'd4;  yv[1] = pack4(15, 15, 15, 15);     ev[1] = pack4(3121, 3121, 3121, 3121);
        dv[2] = 4'd11; yv[2] = pack4(2047, 2047, 2047, 2047); ev[2] = pack4(3327, 3327, 3327, 3327);
        dv[3] = 4'd5;  yv[3] = pack4(32, 33, 31, 64);     ev[3] = pack4(0, 104, 3225, 0);
        for (int i = 0; i < 4; i++) begin
            send_one(1'b1, dv[i], yv[i], 8'(8'h30 + i), rc, rt, re, lat);
            checks++; if (rc !== ev[i]) begin failures++; $display("FAIL decompress_vec%0d got=%h exp=%h", i, rc, ev[i]); end
            checks++; if (rt !== 8'(8'h30 + i)) begin failures++; $display("FAIL decompress_vec%0d_tag got=%h exp=%h", i, rt, 8'(8'h30 + i)); end
        end
    endtask

    task automatic test_unsupported_d;
        logic [47:0] rc; logic [7:0] rt; logic re; int lat;
        send_one(1'b0, 4'd3, pack4(1000, 1000, 1000, 1000), 8'hA5, rc, rt, re, lat);
        checks++; if (rc !== 48'h0) begin failures++; $display("FAIL bad_d_coeff got=%h exp=0", rc); end
        checks++; if (re !== 1'b1) begin failures++; $display("FAIL bad_d_err got=%b exp=1", re); end
        checks++; if (rt !== 8'hA5) begin failures++; $display("FAIL bad_d_tag got=%h exp=a5", rt); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL bad_d_latency got=%0d exp=3", lat); end
        send_one(1'b0, 4'd4, pack4(1000, 1000, 1000, 1000), 8'hA6, rc, rt, re, lat);
        checks++; if (re !== 1'b0) begin failures++; $display("FAIL good_d_err got=%b exp=0", re); end
        checks++; if (rc !== pack4(5, 5, 5, 5)) begin failures++; $display("FAIL good_d_coeff got=%h exp=%h", rc, pack4(5, 5, 5, 5)); end
    endtask

    // Ten beats with per-beat mode/d under a 1,0,0,1 i_ready pattern.
    task automatic test_back_to_back;
        int          dl [5];
        logic [47:0] exp_q [$];
        int sent, recv, cyc;
        logic fire_in, fire_out, stalled;
        logic [47:0] prev_coeff; logic [7:0] prev_tag;
        logic [47:0] c; logic m; int d;
        dl[0] = 1; dl[1] = 4; dl[2] = 5; dl[3] = 10; dl[4] = 11;
        sent = 0; recv = 0; cyc = 0; stalled = 1'b0;
        prev_coeff = '0; prev_tag = '0;
        while (recv < 10 && cyc < 200) begin
            @(negedge i_clk);
            i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            m = 1'(sent % 2);
            d = dl[sent % 5];
            c = pack4(sent * 400, sent * 400 + 37, sent * 400 + 74, 4095 - sent * 111);
            i_valid = (sent < 10);
            i_mode = m; i_d = 4'(d); i_coeff = c; i_tag = 8'(sent);
            #1;
            checks++;
            if (o_ready !== !((sent - recv) == 3 && !i_ready)) begin
                failures++;
                $display("FAIL stream_o_ready cyc=%0d got=%b occupancy=%0d i_ready=%b", cyc, o_ready, sent - recv, i_ready);
            end
            if (stalled) begin
                checks++;
                if (o_coeff !== prev_coeff || o_tag !== prev_tag) begin
                    failures++;
                    $display("FAIL stream_hold got=%h/%h exp=%h/%h", o_coeff, o_tag, prev_coeff, prev_tag);
                end
            end
            stalled = o_valid && !i_ready;
            prev_coeff = o_coeff; prev_tag = o_tag;
            fire_in  = i_valid && o_ready;
            fire_out = o_valid && i_ready;
            if (fire_out) begin
                checks++;
                if (o_tag !== 8'(recv) || exp_q.size() == 0 || o_coeff !== exp_q[0] || o_err !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_beat%0d got tag=%h coeff=%h err=%b", recv, o_tag, o_coeff, o_err);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                recv++;
            end
            if (fire_in) begin
                exp_q.push_back(ref_beat(m, d, c));
                sent++;
            end
            cyc++;
        end
        i_valid = 1'b0;
        checks++; if (recv !== 10) begin failures++; $display("FAIL stream_count got=%0d exp=10", recv); end
        i_ready = 1'b1;
        repeat (4) @(negedge i_clk);
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL stream_extra got valid=%b busy=%b exp=0/0", o_valid, o_busy); end
    endtask

    task automatic test_reset_midflight;
        logic [47:0] rc; logic [7:0] rt; logic re; int lat;
        @(negedge i_clk);
        i_ready = 1'b0;
        i_valid = 1'b1; i_mode = 1'b0; i_d = 4'd4; i_coeff = pack4(7, 8, 9, 10);
        for (int i = 0; i < 3; i++) begin
            i_tag = 8'(8'h50 + i);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midrst_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_o_busy got=%b exp=0", o_busy); end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midrst_ghost%0d got=%b exp=0", i, o_valid); end
        end
        send_one(1'b0, 4'd1, pack4(833, 833, 833, 833), 8'h77, rc, rt, re, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL midrst_latency got=%0d exp=3", lat); end
        checks++; if (rc !== pack4(1, 1, 1, 1)) begin failures++; $display("FAIL midrst_coeff got=%h exp=%h", rc, pack4(1, 1, 1, 1)); end
    endtask

    // Every x in [0,4095] for every supported d, both modes, with random downstream stalls.
    task automatic test_exhaustive;
        int          dl [5];
        logic [47:0] exp_q [$];
        logic [7:0]  tag_q [$];
        int sent, recv, cyc, shown;
        logic fire_in, fire_out;
        logic [47:0] c; logic m; int d;
        dl[0] = 1; dl[1] = 4; dl[2] = 5; dl[3] = 10; dl[4] = 11;
        sent = 0; recv = 0; cyc = 0; shown = 0;
        while (recv < 10240 && cyc < 60000) begin
            @(negedge i_clk);
            i_ready = ($urandom_range(0, 3) != 0);
            m = 1'(sent / 5120);
            d = dl[(sent / 1024) % 5];
            c = pack4((sent % 1024) * 4, (sent % 1024) * 4 + 1, (sent % 1024) * 4 + 2, (sent % 1024) * 4 + 3);
            i_valid = (sent < 10240);
            i_mode = m; i_d = 4'(d); i_coeff = c; i_tag = 8'(sent);
            #1;
            fire_in  = i_valid && o_ready;
            fire_out = o_valid && i_ready;
            if (fire_out) begin
                checks++;
                if (exp_q.size() == 0 || o_coeff !== exp_q[0] || o_tag !== tag_q[0] || o_err !== 1'b0) begin
                    failures++;
                    if (shown < 10)
                        $display("FAIL sweep_beat%0d got coeff=%h tag=%h err=%b", recv, o_coeff, o_tag, o_err);
                    shown++;
                end
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    void'(tag_q.pop_front());
                end
                recv++;
            end
            if (fire_in) begin
                exp_q.push_back(ref_beat(m, d, c));
                tag_q.push_back(8'(sent));
                sent++;
            end
            cyc++;
        end
        i_valid = 1'b0;
        checks++; if (recv !== 10240) begin failures++; $display("FAIL sweep_count got=%0d exp=10240", recv); end
    endtask

    initial begin
        test_reset;
        test_compress_d1;
        test_compress_vectors;
        test_decompress_vectors;
        test_unsupported_d;
        test_back_to_back;
        test_reset_midflight;
        test_exhaustive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
